// File: rtl/seg_shift_driver.sv
// Serial output stage for the 8-digit seven-segment display: snapshots a segment
// frame and shifts it MSB-first into an external shift-register chain with a latch strobe.
module seg_shift_driver #(
  parameter int unsigned HALF  = 4,
  parameter int unsigned NBITS = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [NBITS-1:0] SEG_TXT,
  output logic             seg_clk,
  output logic             seg_dat,
  output logic             seg_load,
  output logic             busy,
  output logic             done
);

  localparam int unsigned CW = $clog2(NBITS + 1);
  localparam int unsigned PW = (HALF > 1) ? $clog2(HALF) : 1;
  localparam logic [PW-1:0] PH_LAST = PW'(HALF - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOW,
    S_HIGH,
    S_LATCH
  } state_t;

  state_t           state_q, state_d;
  logic [NBITS-1:0] sr_q, sr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [PW-1:0]    ph_q, ph_d;
  logic             clk_q, clk_d;
  logic             dat_q, dat_d;
  logic             load_q, load_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             phase_end;

  // State, datapath and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      sr_q    <= '0;
      cnt_q   <= '0;
      ph_q    <= '0;
      clk_q   <= 1'b0;
      dat_q   <= 1'b0;
      load_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      cnt_q   <= cnt_d;
      ph_q    <= ph_d;
      clk_q   <= clk_d;
      dat_q   <= dat_d;
      load_q  <= load_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // Next state; outputs are derived from the next state so they line up with it
  always_comb begin
    state_d   = state_q;
    sr_d      = sr_q;
    cnt_d     = cnt_q;
    ph_d      = ph_q;
    done_d    = 1'b0;
    phase_end = (ph_q == PH_LAST);

    case (state_q)
      S_IDLE: begin
        if (start) begin
          sr_d    = SEG_TXT;
          cnt_d   = CW'(NBITS);
          ph_d    = '0;
          state_d = S_LOW;
        end
      end
      S_LOW: begin
        if (phase_end) begin
          ph_d    = '0;
          state_d = S_HIGH;
        end else begin
          ph_d = ph_q + 1'b1;
        end
      end
      S_HIGH: begin
        if (phase_end) begin
          ph_d    = '0;
          sr_d    = sr_q << 1;
          cnt_d   = cnt_q - 1'b1;
          state_d = (cnt_q == CW'(1)) ? S_LATCH : S_LOW;
        end else begin
          ph_d = ph_q + 1'b1;
        end
      end
      S_LATCH: begin
        if (phase_end) begin
          ph_d    = '0;
          state_d = S_IDLE;
          done_d  = 1'b1;
        end else begin
          ph_d = ph_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    clk_d  = (state_d == S_HIGH);
    dat_d  = ((state_d == S_LOW) || (state_d == S_HIGH)) ? sr_d[NBITS-1] : 1'b0;
    load_d = (state_d == S_LATCH);
    busy_d = (state_d != S_IDLE);
  end

  assign seg_clk  = clk_q;
  assign seg_dat  = dat_q;
  assign seg_load = load_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule

// File: tb/tb_seg_shift_driver.sv
// Bench for seg_shift_driver: three instances (HALF=4,1,3) share stimulus and are
// compared every cycle against a frame-timeline reference model.
module tb_seg_shift_driver;

  localparam int unsigned NB = 64;

  logic          clk;
  logic          rst;
  logic          start;
  logic [NB-1:0] txt;

  logic sclk  [3];
  logic sdat  [3];
  logic sload [3];
  logic sbusy [3];
  logic sdone [3];

  int n_chk = 0;
  int n_err = 0;
  int cyc   = 0;

  seg_shift_driver #(.HALF(4), .NBITS(NB)) u0 (
    .clk(clk), .rst(rst), .start(start), .SEG_TXT(txt),
    .seg_clk(sclk[0]), .seg_dat(sdat[0]), .seg_load(sload[0]),
    .busy(sbusy[0]), .done(sdone[0]));

  seg_shift_driver #(.HALF(1), .NBITS(NB)) u1 (
    .clk(clk), .rst(rst), .start(start), .SEG_TXT(txt),
    .seg_clk(sclk[1]), .seg_dat(sdat[1]), .seg_load(sload[1]),
    .busy(sbusy[1]), .done(sdone[1]));

  seg_shift_driver #(.HALF(3), .NBITS(NB)) u2 (
    .clk(clk), .rst(rst), .start(start), .SEG_TXT(txt),
    .seg_clk(sclk[2]), .seg_dat(sdat[2]), .seg_load(sload[2]),
    .busy(sbusy[2]), .done(sdone[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int unsigned half_of(input int i);
    return (i == 0) ? 4 : (i == 1) ? 1 : 3;
  endfunction

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Reference model: per instance, whether a frame is active, cycles since acceptance,
  // the snapshotted frame, and a pending done cycle.
  bit            m_act [3];
  bit            m_dn  [3];
  int unsigned   m_k   [3];
  logic [NB-1:0] m_frm [3];

  always @(posedge clk) begin
    cyc++;
    for (int i = 0; i < 3; i++) begin
      if (rst) begin
        m_act[i] = 1'b0;
        m_dn[i]  = 1'b0;
        m_k[i]   = 0;
      end else if (m_act[i]) begin
        m_k[i]++;
        if (m_k[i] == NB * 2 * half_of(i) + half_of(i)) begin
          m_act[i] = 1'b0;
          m_dn[i]  = 1'b1;
        end
      end else begin
        m_dn[i] = 1'b0;
        if (start) begin
          m_act[i] = 1'b1;
          m_k[i]   = 0;
          m_frm[i] = txt;
        end
      end
    end
  end

  // Monitor state: rises seen, bits received, busy length, previous sample
  int unsigned   r_n  [3];
  logic [NB-1:0] r_sr [3];
  int unsigned   b_n  [3];
  logic          p_clk[3];
  logic          p_dat[3];

  initial begin
    for (int i = 0; i < 3; i++) begin
      r_n[i] = 0; r_sr[i] = '0; b_n[i] = 0; p_clk[i] = 1'b0; p_dat[i] = 1'b0;
    end
  end

  always @(negedge clk) begin
    int unsigned h, len, k;
    logic e_clk, e_dat, e_load;
    if (cyc > 0) begin
      for (int i = 0; i < 3; i++) begin
        h = half_of(i);
        len = NB * 2 * h;
        k = m_k[i];
        e_clk = 1'b0; e_dat = 1'b0; e_load = 1'b0;
        if (m_act[i]) begin
          if (k < len) begin
            e_clk = ((k % (2 * h)) >= h);
            e_dat = m_frm[i][NB - 1 - k / (2 * h)];
          end else begin
            e_load = 1'b1;
          end
        end
        chk($sformatf("u%0d.seg_clk", i),  64'(sclk[i]),  64'(e_clk));
        chk($sformatf("u%0d.seg_dat", i),  64'(sdat[i]),  64'(e_dat));
        chk($sformatf("u%0d.seg_load", i), 64'(sload[i]), 64'(e_load));
        chk($sformatf("u%0d.busy", i),     64'(sbusy[i]), 64'(m_act[i]));
        chk($sformatf("u%0d.done", i),     64'(sdone[i]), 64'(m_dn[i]));

        if (i == 2) begin
          if (p_clk[i] && sclk[i])
            chk("u2.dat_stable_high", 64'(sdat[i]), 64'(p_dat[i]));
          if (sload[i])
            chk("u2.load_while_clk_low", 64'(sclk[i]), 64'd0);
        end

        if (rst) begin
          r_n[i] = 0; r_sr[i] = '0; b_n[i] = 0;
        end else begin
          if (sbusy[i]) b_n[i]++;
          if (sclk[i] && !p_clk[i]) begin
            r_sr[i] = {r_sr[i][NB-2:0], sdat[i]};
            r_n[i]++;
          end
          if (sdone[i]) begin
            chk($sformatf("u%0d.rise_count", i), 64'(r_n[i]), 64'(NB));
            chk($sformatf("u%0d.frame_rx", i),   r_sr[i],     m_frm[i]);
            chk($sformatf("u%0d.busy_len", i),   64'(b_n[i]), 64'(len + h));
            r_n[i] = 0; r_sr[i] = '0; b_n[i] = 0;
          end
        end
        p_clk[i] = sclk[i];
        p_dat[i] = sdat[i];
      end
    end
  end

  function automatic logic any_active();
    return sbusy[0] | sbusy[1] | sbusy[2] | sdone[0] | sdone[1] | sdone[2];
  endfunction

  task automatic wait_idle(input int max);
    int n;
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (any_active() && n < max);
    chk("idle_timeout", 64'(any_active()), 64'd0);
  endtask

  task automatic pulse_start(input logic [NB-1:0] frame);
    txt = frame;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  initial begin
    int n;
    rst = 1'b1;
    start = 1'b1;
    txt = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    start = 1'b0;
    @(posedge clk); #1;

    // Known frame, then a mid-frame restart attempt with a cleared frame
    pulse_start(64'hFFFF_0000_A5A5_0123);
    repeat (200) @(posedge clk);
    #1;
    pulse_start('0);
    wait_idle(3000);

    // Reset after 20 serial clock rises on the HALF=4 instance
    pulse_start({$urandom, $urandom});
    n = 0;
    while (r_n[0] < 20 && n < 2000) begin
      @(posedge clk); #1;
      n++;
    end
    chk("rise20_timeout", 64'(r_n[0] >= 20), 64'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    pulse_start({$urandom, $urandom});
    wait_idle(3000);

    // Random single frames
    repeat (3) begin
      pulse_start({$urandom, $urandom});
      wait_idle(3000);
    end

    // Continuous start with a frame that keeps changing
    start = 1'b1;
    repeat (600) begin
      txt = {$urandom, $urandom};
      @(posedge clk); #1;
    end
    start = 1'b0;
    wait_idle(3000);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
